rca_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer sharing one WIDTH-bit ripple-carry adder (RCA_FH datapath)

---
 rtl/rca_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_rca_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_arbiter.sv
// Round-robin sequencer that shares one ripple-carry adder between two requesters
// and returns {sum, carry, id} on a registered result port.

module rca_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca_fh #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        rca_fa u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end

    assign cout = carry[WIDTH];
endmodule

module rca_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id,
    output logic             busy
);
    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
    // Requesters may drop valid at any time; ready never depends on a queued request.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             last_grant, last_grant_nxt;
    logic [WIDTH-1:0] op_a, op_a_nxt;
    logic [WIDTH-1:0] op_b, op_b_nxt;
    logic             op_cin, op_cin_nxt;
    logic             op_id, op_id_nxt;
    logic             res_valid_nxt;
    logic [WIDTH-1:0] res_sum_nxt;
    logic             res_carry_nxt;
    logic             res_id_nxt;
    logic             busy_nxt;

    logic             grant_vld;
    logic             grant_id;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    rca_fh #(.WIDTH(WIDTH)) u_rca (
        .a   (op_a),
        .b   (op_b),
        .cin (op_cin),
        .sum (add_sum),
        .cout(add_cout)
    );

    // Contention goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = rst_n && grant_vld && !grant_id;
    assign req1_ready = rst_n && grant_vld && grant_id;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        op_a_nxt       = op_a;
        op_b_nxt       = op_b;
        op_cin_nxt     = op_cin;
        op_id_nxt      = op_id;
        res_valid_nxt  = res_valid;
        res_sum_nxt    = res_sum;
        res_carry_nxt  = res_carry;
        res_id_nxt     = res_id;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    op_a_nxt       = grant_id ? req1_a : req0_a;
                    op_b_nxt       = grant_id ? req1_b : req0_b;
                    op_cin_nxt     = grant_id ? req1_cin : req0_cin;
                    op_id_nxt      = grant_id;
                    last_grant_nxt = grant_id;
                    state_nxt      = CALC;
                end
            end
            CALC: begin
                res_sum_nxt   = add_sum;
                res_carry_nxt = add_cout;
                res_id_nxt    = op_id;
                res_valid_nxt = 1'b1;
                state_nxt     = HOLD;
            end
            HOLD: begin
                // Result fields are left untouched after the transfer on purpose.
                if (res_ready) begin
                    res_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                res_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_cin     <= 1'b0;
            op_id      <= 1'b0;
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_carry  <= 1'b0;
            res_id     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            op_a       <= op_a_nxt;
            op_b       <= op_b_nxt;
            op_cin     <= op_cin_nxt;
            op_id      <= op_id_nxt;
            res_valid  <= res_valid_nxt;
            res_sum    <= res_sum_nxt;
            res_carry  <= res_carry_nxt;
            res_id     <= res_id_nxt;
            busy       <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_rca_arbiter.sv
// Bench for rca_arbiter: randomized requests checked against a transaction-level
// model (grant order, a+b+cin arithmetic, fixed 2-edge latency).

module tb_rca_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic         res_valid, res_ready;
    logic [W-1:0] res_sum;
    logic         res_carry, res_id, busy;

    int vectors     = 0;
    int miscompares = 0;

    // {id, carry, sum} of every accepted request, oldest first
    logic [W+1:0] exp_q[$];
    logic         model_last;

    always #5 clk = ~clk;

    rca_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_cin  (req0_cin),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_cin  (req1_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id),
        .busy      (busy)
    );

    function automatic logic [W+1:0] ref_result(input logic id, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic cin);
        logic [W:0] total;
        total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        return {id, total};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        res_ready = 1'b1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        model_last = 1'b1;
        exp_q.delete();
    endtask

    // Present one request and hold it until accepted; ok=0 if never granted.
    task automatic drive_one(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, output logic ok);
        ok = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end
        for (int i = 0; i < 10 && !ok; i++) begin
            #1;
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                exp_q.push_back(ref_result(id, a, b, cin));
                model_last = id;
            end
            tick();
        end
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic v0, v1;
        rst_n = 1'b1;
        idle_inputs();
        tick();
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
            res_ready = 1'($urandom_range(0, 1));
            tick();
            vectors++;
            if ({res_valid, res_sum, res_carry, res_id, busy, req0_ready, req1_ready} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: valid=%b sum=%h carry=%b id=%b busy=%b rdy=%b%b required all 0",
                         res_valid, res_sum, res_carry, res_id, busy, req0_ready, req1_ready);
            end
        end
        rst_n = 1'b1;
        model_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            req0_valid = v0; req1_valid = v1;
            #1;
            vectors++;
            if ({req0_ready, req1_ready, busy} !== {v0, v1 & ~v0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_release_ready: v=%b%b rdy=%b%b busy=%b required rdy=%b%b busy=0",
                         v0, v1, req0_ready, req1_ready, busy, v0, v1 & ~v0);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_single();
        logic ok;
        apply_reset();
        drive_one(1'b0, 32'd25, 32'd17, 1'b1, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_grant: req0_ready never rose, required within 10 cycles");
        end
        vectors++;
        if ({res_valid, busy, req0_ready} !== 3'b010) begin
            miscompares++;
            $display("FAIL single_calc: valid=%b busy=%b rdy0=%b required 0 1 0", res_valid, busy, req0_ready);
        end
        tick();
        vectors++;
        if ({res_valid, res_sum, res_carry, res_id} !== {1'b1, 32'd43, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL single_result: valid=%b sum=%0d carry=%b id=%b required 1 43 0 0",
                     res_valid, res_sum, res_carry, res_id);
        end
        tick();
        vectors++;
        if ({res_valid, busy, res_sum} !== {1'b0, 1'b0, 32'd43}) begin
            miscompares++;
            $display("FAIL single_retire: valid=%b busy=%b sum=%0d required 0 0 43", res_valid, busy, res_sum);
        end
    endtask

    task automatic test_alternate();
        int           got = 0;
        int           phase = 0;
        logic         exp_r0, exp_r1, g;
        logic [W+1:0] exp;
        apply_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = $urandom_range(0, 100); req0_b = $urandom_range(0, 100); req0_cin = 1'($urandom_range(0, 1));
        req1_a = $urandom_range(0, 100); req1_b = $urandom_range(0, 100); req1_cin = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            #1;
            exp_r0 = (phase == 0) && model_last;
            exp_r1 = (phase == 0) && !model_last;
            vectors++;
            if ({req0_ready, req1_ready, res_valid} !== {exp_r0, exp_r1, phase == 2}) begin
                miscompares++;
                $display("FAIL alt_handshake: rdy=%b%b valid=%b required %b%b %b",
                         req0_ready, req1_ready, res_valid, exp_r0, exp_r1, phase == 2);
            end
            if (phase == 2 && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                vectors++;
                if ({res_id, res_carry, res_sum} !== exp || res_id !== 1'(got % 2)) begin
                    miscompares++;
                    $display("FAIL alt_result: id=%b carry=%b sum=%0d required id=%b carry=%b sum=%0d",
                             res_id, res_carry, res_sum, exp[W+1], exp[W], exp[W-1:0]);
                end
                got++;
            end
            g = ~model_last;
            if (phase == 0) begin
                exp_q.push_back(g ? ref_result(1'b1, req1_a, req1_b, req1_cin)
                                  : ref_result(1'b0, req0_a, req0_b, req0_cin));
                model_last = g;
            end
            tick();
            if (phase == 0) begin
                if (g) begin
                    req1_a = $urandom_range(0, 100); req1_b = $urandom_range(0, 100); req1_cin = 1'($urandom_range(0, 1));
                end else begin
                    req0_a = $urandom_range(0, 100); req0_b = $urandom_range(0, 100); req0_cin = 1'($urandom_range(0, 1));
                end
            end
            phase = (phase + 1) % 3;
        end
        vectors++;
        if (got != 10) begin
            miscompares++;
            $display("FAIL alt_timeout: results=%0d required 10", got);
        end
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_overflow();
        logic         ok;
        logic [W+1:0] exp;
        logic [W-1:0] av[2];
        logic [W-1:0] bv[2];
        logic         cv[2];
        av[0] = 32'hFFFF_FFFF; bv[0] = 32'h0;         cv[0] = 1'b1;
        av[1] = 32'h8000_0000; bv[1] = 32'h8000_0000; cv[1] = 1'b0;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            drive_one(1'b0, av[k], bv[k], cv[k], ok);
            tick();
            exp = exp_q.pop_front();
            vectors++;
            if (!ok || res_valid !== 1'b1 || {res_id, res_carry, res_sum} !== exp
                || {res_carry, res_sum} !== {1'b1, 32'h0}) begin
                miscompares++;
                $display("FAIL overflow_%0d: ok=%b valid=%b carry=%b sum=%h required carry=1 sum=0",
                         k, ok, res_valid, res_carry, res_sum);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic         ok;
        logic [W+1:0] exp;
        apply_reset();
        res_ready = 1'b0;
        drive_one(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), ok);
        tick();
        exp = exp_q.pop_front();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_a = $urandom; req1_a = $urandom; req0_b = $urandom; req1_b = $urandom;
            #1;
            vectors++;
            if (!ok || {res_valid, busy, req0_ready, req1_ready} !== 4'b1100
                || {res_id, res_carry, res_sum} !== exp) begin
                miscompares++;
                $display("FAIL backpressure_hold: valid=%b busy=%b rdy=%b%b sum=%h required 1 1 00 sum=%h",
                         res_valid, busy, req0_ready, req1_ready, res_sum, exp[W-1:0]);
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        vectors++;
        if ({res_valid, busy, req0_ready, req1_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL backpressure_release: valid=%b busy=%b rdy=%b%b required 0 0 01",
                     res_valid, busy, req0_ready, req1_ready);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_midop();
        logic ok;
        apply_reset();
        drive_one(1'b1, $urandom, $urandom, 1'b1, ok);
        exp_q.delete();
        req1_valid = 1'b1; req0_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (!ok || {res_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL midop_reset: ok=%b valid=%b busy=%b required 0 0", ok, res_valid, busy);
        end
        tick();
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready, res_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL midop_priority: rdy=%b%b valid=%b required 10 0", req0_ready, req1_ready, res_valid);
        end
        idle_inputs();
        repeat (3) tick();
        vectors++;
        if ({res_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL midop_stale: valid=%b busy=%b required 0 0", res_valid, busy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_overflow();
        test_backpressure();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
